// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: walks a one-hot row drive, synchronises the column lines,
// debounces a single key press/release and emits a one-cycle key event with its hex code.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV        = 1000,
  parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] columns,
  output logic [3:0] rows,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned MaxCount = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int unsigned CntW     = $clog2(MaxCount + 1);

  localparam logic [CntW-1:0] DwellLast = CntW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] DebLast   = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne    = CntW'(1);

  // Nibble {row,col} of this constant holds the key code; entry 0 (row0/col0) is the LSB.
  localparam logic [63:0] KeyMap = 64'hC321_D654_E987_FB0A;

  typedef enum logic [2:0] {
    StScan,
    StDebounce,
    StEmit,
    StHold,
    StRelease
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] dwell_q, dwell_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      rows_q, rows_d;
  logic [3:0]      lat_col_q, lat_col_d;
  logic [3:0]      key_code_q, key_code_d;
  logic [3:0]      col_meta_q, col_s_q;

  logic [3:0] rows_next;
  logic       col_onehot;
  logic       col_match;
  logic       col_released;

  function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    unique case (oh)
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  function automatic logic [3:0] decode_key(input logic [3:0] row_oh, input logic [3:0] col_oh);
    logic [3:0] sel;
    sel = {onehot_idx(row_oh), onehot_idx(col_oh)};
    return KeyMap[{sel, 2'b00} +: 4];
  endfunction

  // Column lines are asynchronous to clk; nothing downstream looks at them unsynchronised.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_meta_q <= 4'b0000;
      col_s_q    <= 4'b0000;
    end else begin
      col_meta_q <= columns;
      col_s_q    <= col_meta_q;
    end
  end

  assign rows_next    = {rows_q[2:0], rows_q[3]};
  assign col_onehot   = (col_s_q != 4'b0000) && ((col_s_q & (col_s_q - 4'd1)) == 4'b0000);
  assign col_match    = (col_s_q == lat_col_q);
  assign col_released = ((col_s_q & lat_col_q) == 4'b0000);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StScan;
      dwell_q    <= '0;
      cnt_q      <= '0;
      rows_q     <= 4'b0001;
      lat_col_q  <= 4'b0000;
      key_code_q <= 4'h0;
    end else begin
      state_q    <= state_d;
      dwell_q    <= dwell_d;
      cnt_q      <= cnt_d;
      rows_q     <= rows_d;
      lat_col_q  <= lat_col_d;
      key_code_q <= key_code_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    dwell_d    = dwell_q;
    cnt_d      = cnt_q;
    rows_d     = rows_q;
    lat_col_d  = lat_col_q;
    key_code_d = key_code_q;
    unique case (state_q)
      StScan: begin
        if (dwell_q == DwellLast) begin
          dwell_d = '0;
          if (col_onehot) begin
            lat_col_d = col_s_q;
            cnt_d     = '0;
            state_d   = StDebounce;
          end else begin
            rows_d = rows_next;
          end
        end else begin
          dwell_d = dwell_q + CntOne;
        end
      end
      StDebounce: begin
        if (!col_match) begin
          cnt_d   = '0;
          dwell_d = '0;
          rows_d  = rows_next;
          state_d = StScan;
        end else if (cnt_q == DebLast) begin
          // Code is loaded on entry so it is already valid during the key_valid cycle.
          cnt_d      = '0;
          key_code_d = decode_key(rows_q, lat_col_q);
          state_d    = StEmit;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StEmit: begin
        cnt_d   = '0;
        state_d = StHold;
      end
      StHold: begin
        if (col_released) begin
          cnt_d   = '0;
          state_d = StRelease;
        end
      end
      StRelease: begin
        if (!col_released) begin
          cnt_d   = '0;
          state_d = StHold;
        end else if (cnt_q == DebLast) begin
          cnt_d   = '0;
          dwell_d = '0;
          rows_d  = rows_next;
          state_d = StScan;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: begin
        state_d   = StScan;
        dwell_d   = '0;
        cnt_d     = '0;
        rows_d    = 4'b0001;
        lat_col_d = 4'b0000;
      end
    endcase
  end

  always_comb begin
    rows      = rows_q;
    key_code  = key_code_q;
    key_valid = (state_q == StEmit);
    key_held  = (state_q == StEmit) || (state_q == StHold) || (state_q == StRelease);
  end

  a_valid_single : assert property (@(posedge clk) disable iff (!reset)
    key_valid |=> !key_valid);
  a_rows_onehot : assert property (@(posedge clk) disable iff (!reset)
    $onehot(rows));

endmodule
